prbs9_qpsk_source: RTL and testbench

- Dual PRBS9 bit source feeding the QPSK mapper. Produces one bit pair (bit_I, bit_Q) per accepted symbol from two independent LFSRs.
- Sits directly upstream of the mapper. o_bit_I/o_bit_Q wire straight to the mapper's bit_I/bit_Q inputs.
- Provides a valid/ready handshake toward the downstream symbol pipeline, plus period-wrap and seed-error status for the test harness.

---
 rtl/prbs9_qpsk_source.sv | 100 ++++++++++
 tb/tb_prbs9_qpsk_source.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/prbs9_qpsk_source.sv
// Dual PRBS9 (x^9+x^5+1) bit-pair source for the QPSK mapper, with valid/ready
// output handshake, runtime reseed, period-wrap pulse and sticky zero-seed flag.
module prbs9_qpsk_source #(
  parameter logic [8:0] SEED_I = 9'h1AA,
  parameter logic [8:0] SEED_Q = 9'h1FE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_ready,
  input  logic       i_reseed,
  input  logic [8:0] i_seed_I,
  input  logic [8:0] i_seed_Q,
  output logic       o_bit_I,
  output logic       o_bit_Q,
  output logic       o_valid,
  output logic       o_wrap,
  output logic       o_seed_err
);

  localparam logic [8:0] LAST_SYM = 9'd510;

  logic [8:0] lfsr_i_q, lfsr_i_d;
  logic [8:0] lfsr_q_q, lfsr_q_d;
  logic [8:0] cnt_q, cnt_d;
  logic       bit_i_q, bit_i_d;
  logic       bit_q_q, bit_q_d;
  logic       valid_q, valid_d;
  logic       wrap_q, wrap_d;
  logic       err_q, err_d;
  logic       adv;

  function automatic logic [8:0] lfsr_step(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  // A zero seed would lock the LFSR; fall back to the default seed instead.
  function automatic logic [8:0] seed_sel(input logic [8:0] seed, input logic [8:0] dflt);
    return (seed == 9'd0) ? dflt : seed;
  endfunction

  assign adv = i_en && (!valid_q || i_ready) && !i_reseed;

  always_comb begin
    lfsr_i_d = lfsr_i_q;
    lfsr_q_d = lfsr_q_q;
    cnt_d    = cnt_q;
    bit_i_d  = bit_i_q;
    bit_q_d  = bit_q_q;
    valid_d  = valid_q;
    wrap_d   = 1'b0;
    err_d    = err_q;
    if (i_reseed) begin
      lfsr_i_d = seed_sel(i_seed_I, SEED_I);
      lfsr_q_d = seed_sel(i_seed_Q, SEED_Q);
      cnt_d    = 9'd0;
      valid_d  = 1'b0;
      err_d    = err_q || (i_seed_I == 9'd0) || (i_seed_Q == 9'd0);
    end else if (adv) begin
      bit_i_d  = lfsr_i_q[8];
      bit_q_d  = lfsr_q_q[8];
      valid_d  = 1'b1;
      lfsr_i_d = lfsr_step(lfsr_i_q);
      lfsr_q_d = lfsr_step(lfsr_q_q);
      cnt_d    = (cnt_q == LAST_SYM) ? 9'd0 : cnt_q + 9'd1;
      wrap_d   = (cnt_q == LAST_SYM);
    end else if (valid_q && i_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_i_q <= SEED_I;
      lfsr_q_q <= SEED_Q;
      cnt_q    <= 9'd0;
      bit_i_q  <= 1'b0;
      bit_q_q  <= 1'b0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      lfsr_i_q <= lfsr_i_d;
      lfsr_q_q <= lfsr_q_d;
      cnt_q    <= cnt_d;
      bit_i_q  <= bit_i_d;
      bit_q_q  <= bit_q_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign o_bit_I    = bit_i_q;
  assign o_bit_Q    = bit_q_q;
  assign o_valid    = valid_q;
  assign o_wrap     = wrap_q;
  assign o_seed_err = err_q;

endmodule

// File: tb/tb_prbs9_qpsk_source.sv
// Randomized bench for prbs9_qpsk_source against a sequence-array reference
// built from the PRBS9 recurrence a[n+9] = a[n] ^ a[n+4].
module tb_prbs9_qpsk_source;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic       i_ready = 1'b0;
  logic       i_reseed = 1'b0;
  logic [8:0] i_seed_I = 9'd0;
  logic [8:0] i_seed_Q = 9'd0;
  logic       o_bit_I, o_bit_Q, o_valid, o_wrap, o_seed_err;

  prbs9_qpsk_source dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_ready(i_ready),
    .i_reseed(i_reseed), .i_seed_I(i_seed_I), .i_seed_Q(i_seed_Q),
    .o_bit_I(o_bit_I), .o_bit_Q(o_bit_Q), .o_valid(o_valid),
    .o_wrap(o_wrap), .o_seed_err(o_seed_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wrap_cnt = 0;
  int diff_cnt = 0;

  // Reference: one full period of each output bit stream, indexed by symbol number
  bit ref_i [0:510];
  bit ref_q [0:510];
  bit m_valid, m_bi, m_bq, m_wrap, m_err;
  int m_idx;

  task automatic build_i(input logic [8:0] seed);
    bit a [0:519];
    for (int k = 0; k < 9; k++) a[k] = seed[8-k];
    for (int n = 0; n + 9 < 520; n++) a[n+9] = a[n] ^ a[n+4];
    for (int n = 0; n < 511; n++) ref_i[n] = a[n];
  endtask

  task automatic build_q(input logic [8:0] seed);
    bit a [0:519];
    for (int k = 0; k < 9; k++) a[k] = seed[8-k];
    for (int n = 0; n + 9 < 520; n++) a[n+9] = a[n] ^ a[n+4];
    for (int n = 0; n < 511; n++) ref_q[n] = a[n];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_valid = 0; m_bi = 0; m_bq = 0; m_wrap = 0; m_err = 0; m_idx = 0;
      build_i(9'h1AA);
      build_q(9'h1FE);
    end else if (i_reseed) begin
      m_valid = 0; m_wrap = 0; m_idx = 0;
      if (i_seed_I == 0 || i_seed_Q == 0) m_err = 1;
      build_i(i_seed_I == 0 ? 9'h1AA : i_seed_I);
      build_q(i_seed_Q == 0 ? 9'h1FE : i_seed_Q);
    end else if (i_en && (!m_valid || i_ready)) begin
      m_bi = ref_i[m_idx];
      m_bq = ref_q[m_idx];
      m_valid = 1;
      m_wrap = (m_idx == 510);
      m_idx = (m_idx + 1) % 511;
    end else begin
      if (m_valid && i_ready) m_valid = 0;
      m_wrap = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", o_valid, m_valid);
    chk("wrap", o_wrap, m_wrap);
    chk("seed_err", o_seed_err, m_err);
    chk("bit_I", o_bit_I, m_bi);
    chk("bit_Q", o_bit_Q, m_bq);
    if (o_wrap) wrap_cnt++;
    if (o_valid && (o_bit_I != o_bit_Q)) diff_cnt++;
  endtask

  initial begin
    m_valid = 0; m_bi = 0; m_bq = 0; m_wrap = 0; m_err = 0; m_idx = 0;
    build_i(9'h1AA);
    build_q(9'h1FE);

    // Reset
    cycle(); cycle();
    chk("rst_outs", {o_valid, o_bit_I, o_bit_Q, o_wrap, o_seed_err}, 5'b0);

    // Continuous free-run from reset
    rst_n = 1; i_en = 1; i_ready = 1; wrap_cnt = 0; diff_cnt = 0;
    cycle();
    chk("first_valid", o_valid, 1);
    chk("pair0", {o_bit_I, o_bit_Q}, 2'b11);
    cycle();
    chk("pair1", {o_bit_I, o_bit_Q}, 2'b11);
    cycle();
    chk("pair2", {o_bit_I, o_bit_Q}, 2'b01);
    for (int c = 0; c < 1019; c++) cycle();
    chk("wraps_1022", wrap_cnt, 2);
    chk("i_ne_q", (diff_cnt > 0), 1);

    // Reseed with default seeds mid-stream
    i_reseed = 1; i_seed_I = 9'h1AA; i_seed_Q = 9'h1FE;
    cycle();
    chk("reseed_valid", o_valid, 0);
    i_reseed = 0; wrap_cnt = 0;
    cycle();
    chk("rs_pair0", {o_bit_I, o_bit_Q}, 2'b11);
    cycle();
    chk("rs_pair1", {o_bit_I, o_bit_Q}, 2'b11);
    cycle();
    chk("rs_pair2", {o_bit_I, o_bit_Q}, 2'b01);
    for (int c = 0; c < 508; c++) cycle();
    chk("rs_wraps", wrap_cnt, 1);

    // Random ready toggling against the reference
    for (int c = 0; c < 1500; c++) begin
      i_ready = 1'($urandom_range(0, 1));
      i_en = ($urandom_range(0, 9) != 0);
      cycle();
    end

    // Zero I seed
    i_ready = 1; i_en = 1;
    i_reseed = 1; i_seed_I = 9'd0; i_seed_Q = 9'h0F0;
    cycle();
    chk("zero_seed_err", o_seed_err, 1);
    i_reseed = 0;
    cycle();
    chk("zs_bitI", o_bit_I, 1);
    chk("zs_bitQ", o_bit_Q, 0);

    // Random traffic including random reseeds
    for (int c = 0; c < 2000; c++) begin
      i_ready = 1'($urandom_range(0, 1));
      i_en = ($urandom_range(0, 9) != 0);
      i_reseed = ($urandom_range(0, 99) == 0);
      i_seed_I = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
      i_seed_Q = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
      cycle();
    end
    i_reseed = 0;
    chk("err_sticky", o_seed_err, 1);

    // Reset during a stall
    i_en = 1; i_ready = 0;
    cycle(); cycle();
    chk("stall_valid", o_valid, 1);
    rst_n = 0;
    cycle();
    chk("stall_rst_outs", {o_valid, o_bit_I, o_bit_Q, o_wrap, o_seed_err}, 5'b0);
    rst_n = 1; i_ready = 1;
    cycle();
    chk("post_rst_pair0", {o_bit_I, o_bit_Q}, 2'b11);
    cycle();
    chk("post_rst_pair1", {o_bit_I, o_bit_Q}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
